// File: rtl/motion_estimator_core.sv
// motion_estimator_core: full-search block-matching motion estimator.
// Compares a 16x16 reference block (ROM port R) against all 256 candidate
// blocks, with displacements (dx, dy) in [-8, 7]^2, inside a 32x32 search
// window (dual-read ROM ports S1/S2). Reports the minimum SAD, saturated to
// 8 bits, and its displacement.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   start      level-sensitive run request; dropping it aborts or leaves DONE
//   R          reference pixel, valid one cycle after AddressR
//   S1, S2     search pixels, valid one cycle after AddressS1 / AddressS2
//   AddressR   reference address r*16 + c
//   AddressS1  search address for the even-dx candidate of the current pair
//   AddressS2  search address for the odd-dx candidate of the current pair
//   BestDist   min(best SAD, 255)
//   motionX/Y  two's-complement displacement of the best candidate
//   completed  high while results are final
module motion_estimator_core #(
  parameter int unsigned BLK = 16,
  parameter int unsigned WIN = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] R,
  input  logic [7:0] S1,
  input  logic [7:0] S2,
  output logic [7:0] AddressR,
  output logic [9:0] AddressS1,
  output logic [9:0] AddressS2,
  output logic [7:0] BestDist,
  output logic [3:0] motionX,
  output logic [3:0] motionY,
  output logic       completed
);

  // Per-pair cycle counter: 0..255 issue addresses, data/diff pipeline drains
  // through 257, the finished SADs are compared at DrainEnd.
  localparam logic [8:0] LastIssue = 9'(BLK * BLK - 1);
  localparam logic [8:0] AccFirst  = 9'd2;
  localparam logic [8:0] AccLast   = 9'(BLK * BLK + 1);
  localparam logic [8:0] DrainEnd  = 9'(BLK * BLK + 2);
  localparam logic [6:0] LastPair  = 7'd127;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [8:0]  cnt_q;
  // pair_q[6:3] = dy + 8, pair_q[2:0] = (dx + 8) / 2 for the even member.
  logic [6:0]  pair_q;
  logic [7:0]  diff1_q, diff2_q;
  logic [15:0] acc1_q, acc2_q;
  logic [15:0] best_q;

  // Address generation for the next pixel to issue.
  logic [7:0]  pix_n;
  logic [6:0]  pair_n;
  logic [4:0]  row, col1, col2;
  logic [7:0]  addr_r_d;
  logic [9:0]  addr_s1_d, addr_s2_d;

  always_comb begin
    pix_n  = cnt_q[7:0] + 8'd1;
    pair_n = pair_q;
    if (state_q != StRun) begin
      pix_n  = '0;
      pair_n = '0;
    end else if (cnt_q == DrainEnd) begin
      pix_n  = '0;
      pair_n = pair_q + 7'd1;
    end
    row       = {1'b0, pix_n[7:4]} + {1'b0, pair_n[6:3]};
    col1      = {1'b0, pix_n[3:0]} + {1'b0, pair_n[2:0], 1'b0};
    col2      = col1 + 5'd1;
    addr_r_d  = pix_n;
    addr_s1_d = 10'(row) * 10'(WIN) + 10'(col1);
    addr_s2_d = 10'(row) * 10'(WIN) + 10'(col2);
  end

  logic [7:0] diff1_d, diff2_d;

  always_comb begin
    diff1_d = (R >= S1) ? (R - S1) : (S1 - R);
    diff2_d = (R >= S2) ? (R - S2) : (S2 - R);
  end

  // Best-candidate update: SAD1 (even dx) is earlier in scan order than SAD2,
  // and strict less-than keeps the earliest of equal candidates.
  logic [3:0]  idx1, idx2;
  logic [15:0] best_d;
  logic [3:0]  mx_d, my_d;

  always_comb begin
    idx1   = {pair_q[2:0], 1'b0};
    idx2   = {pair_q[2:0], 1'b1};
    best_d = best_q;
    mx_d   = motionX;
    my_d   = motionY;
    if (pair_q == 7'd0 || acc1_q < best_q) begin
      best_d = acc1_q;
      mx_d   = {~idx1[3], idx1[2:0]};
      my_d   = {~pair_q[6], pair_q[5:3]};
    end
    if (acc2_q < best_d) begin
      best_d = acc2_q;
      mx_d   = {~idx2[3], idx2[2:0]};
      my_d   = {~pair_q[6], pair_q[5:3]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pair_q    <= '0;
      diff1_q   <= '0;
      diff2_q   <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      best_q    <= 16'hFFFF;
      AddressR  <= '0;
      AddressS1 <= '0;
      AddressS2 <= '0;
      BestDist  <= 8'hFF;
      motionX   <= '0;
      motionY   <= '0;
      completed <= 1'b0;
    end else begin
      diff1_q <= diff1_d;
      diff2_q <= diff2_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            pair_q    <= '0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            best_q    <= 16'hFFFF;
            BestDist  <= 8'hFF;
            motionX   <= '0;
            motionY   <= '0;
            AddressR  <= addr_r_d;
            AddressS1 <= addr_s1_d;
            AddressS2 <= addr_s2_d;
          end
        end
        StRun: begin
          if (!start) begin
            // Abort: results and addresses hold until the next run clears them.
            state_q <= StIdle;
          end else begin
            if (cnt_q < LastIssue) begin
              AddressR  <= addr_r_d;
              AddressS1 <= addr_s1_d;
              AddressS2 <= addr_s2_d;
            end
            if (cnt_q >= AccFirst && cnt_q <= AccLast) begin
              acc1_q <= acc1_q + 16'(diff1_q);
              acc2_q <= acc2_q + 16'(diff2_q);
            end
            if (cnt_q == DrainEnd) begin
              cnt_q    <= '0;
              acc1_q   <= '0;
              acc2_q   <= '0;
              best_q   <= best_d;
              BestDist <= (|best_d[15:8]) ? 8'hFF : best_d[7:0];
              motionX  <= mx_d;
              motionY  <= my_d;
              if (pair_q == LastPair) begin
                state_q   <= StDone;
                completed <= 1'b1;
              end else begin
                pair_q    <= pair_n;
                AddressR  <= addr_r_d;
                AddressS1 <= addr_s1_d;
                AddressS2 <= addr_s2_d;
              end
            end else begin
              cnt_q <= cnt_q + 9'd1;
            end
          end
        end
        StDone: begin
          if (!start) begin
            state_q   <= StIdle;
            completed <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_motion_estimator_core.sv
module tb_motion_estimator_core;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] R  = '0;
  logic [7:0] S1 = '0;
  logic [7:0] S2 = '0;
  logic [7:0] AddressR;
  logic [9:0] AddressS1, AddressS2;
  logic [7:0] BestDist;
  logic [3:0] motionX, motionY;
  logic       completed;

  logic [7:0] rmem [256];
  logic [7:0] smem [1024];

  int n_cmp = 0;
  int n_err = 0;

  motion_estimator_core dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .R         (R),
    .S1        (S1),
    .S2        (S2),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .BestDist  (BestDist),
    .motionX   (motionX),
    .motionY   (motionY),
    .completed (completed)
  );

  always #5 clock = ~clock;

  // Synchronous ROMs: data appears one cycle after the address.
  always @(posedge clock) begin
    R  <= rmem[AddressR];
    S1 <= smem[AddressS1];
    S2 <= smem[AddressS2];
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exhaustive search straight from the definition of SAD and scan order.
  task automatic model(output int best, output int mx, output int my);
    int sad, a, b;
    best = 0;
    mx   = 0;
    my   = 0;
    for (int dy = -8; dy < 8; dy++) begin
      for (int dx = -8; dx < 8; dx++) begin
        sad = 0;
        for (int r = 0; r < 16; r++) begin
          for (int c = 0; c < 16; c++) begin
            a = int'(rmem[r * 16 + c]);
            b = int'(smem[(r + dy + 8) * 32 + (c + dx + 8)]);
            sad += (a > b) ? (a - b) : (b - a);
          end
        end
        if ((dx == -8 && dy == -8) || sad < best) begin
          best = sad;
          mx   = dx;
          my   = dy;
        end
      end
    end
  endtask

  task automatic check_result(input string tag);
    int best, mx, my;
    model(best, mx, my);
    check_val({tag, "_completed"}, int'(completed), 1);
    check_val({tag, "_bestdist"}, int'(BestDist), (best > 255) ? 255 : best);
    check_val({tag, "_motionx"}, int'(motionX), mx & 15);
    check_val({tag, "_motiony"}, int'(motionY), my & 15);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!completed && cyc < 40000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_val({tag, "_done_reached"}, int'(completed), 1);
    check_val({tag, "_latency_ok"}, int'(cyc >= 33151 && cyc <= 33155), 1);
  endtask

  initial begin
    int pr, pc, cdx, cdy, v;
    logic [7:0] bd_hold;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_completed", int'(completed), 0);
    check_val("rst_bestdist", int'(BestDist), 255);
    check_val("rst_motionx", int'(motionX), 0);
    check_val("rst_motiony", int'(motionY), 0);
    check_val("rst_addr_r", int'(AddressR), 0);
    check_val("rst_addr_s1", int'(AddressS1), 0);
    check_val("rst_addr_s2", int'(AddressS2), 0);
    reset_n = 1'b1;

    // Run 1 data: random window holding a copy of R at a random displacement,
    // with one pixel off by 5.
    for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1024; i++) smem[i] = 8'($urandom_range(0, 255));
    cdx = $urandom_range(0, 15);
    cdy = $urandom_range(0, 15);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        smem[(r + cdy) * 32 + (c + cdx)] = rmem[r * 16 + c];
    pr = $urandom_range(0, 15);
    pc = $urandom_range(0, 15);
    v  = int'(rmem[pr * 16 + pc]);
    smem[(pr + cdy) * 32 + (pc + cdx)] = 8'((v >= 5) ? v - 5 : v + 5);

    // Abort by dropping start mid-run.
    @(posedge clock);
    #1;
    start = 1'b1;
    repeat (500) @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    check_val("abort_completed", int'(completed), 0);
    repeat (5) @(posedge clock);
    #1;
    check_val("abort_completed_idle", int'(completed), 0);

    // Reset pulse mid-run, start held high throughout.
    start = 1'b1;
    repeat (1000) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_val("midrst_completed", int'(completed), 0);
    check_val("midrst_bestdist", int'(BestDist), 255);
    check_val("midrst_motionx", int'(motionX), 0);
    check_val("midrst_motiony", int'(motionY), 0);

    wait_done("run1");
    check_result("run1");

    // Results frozen while start stays high.
    repeat (5) @(posedge clock);
    #1;
    check_result("run1_hold");

    // Leaving DONE: completed falls next cycle, results remain.
    bd_hold = BestDist;
    start = 1'b0;
    @(posedge clock);
    #1;
    check_val("exit_completed", int'(completed), 0);
    check_val("exit_bestdist_hold", int'(BestDist), int'(bd_hold));

    // Run 2: every candidate has the same large SAD, so the result saturates
    // and the tie rule must keep (-8,-8).
    for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom_range(128, 255));
    for (int i = 0; i < 1024; i++) smem[i] = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    start = 1'b1;
    wait_done("run2");
    check_result("run2");
    check_val("run2_motionx_tie", int'(motionX), 8);
    check_val("run2_bestdist_sat", int'(BestDist), 255);
    start = 1'b0;
    @(posedge clock);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
